ldpc_iter_ctrl: RTL and testbench
=================================

Name: ldpc_iter_ctrl

Overview:
- Iteration scheduler for the LDPC decoder core.
- Sequences one check-node phase (CNU bank) and one variable-node phase (VNU bank) per decoding iteration.
- Generates intrinsic-RAM read addresses and hard-decision write strobes.
- Counts iterations and terminates on parity success, iteration limit or abort; start/done handshake to the host.

Parameters:
- N_COLS, 4, number of column groups processed serially per phase (addresses 0..N_COLS-1)
- ADDR_W, 2, width of ram_addr/hd_addr; must satisfy 2^ADDR_W >= N_COLS
- CNU_LAT, 2, CNU pipeline depth in cycles (drain after last issue)
- VNU_LAT, 2, VNU pipeline depth in cycles (sum stage + output stage)
- ITER_W, 4, width of iteration counter and max_iter

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin decode; sampled only in IDLE
- abort  in  1  cancel decode from any non-IDLE state
- max_iter  in  ITER_W  iteration limit, sampled on accepted start; 0 treated as 1
- parity_ok  in  1  all parity checks satisfied; sampled only in CHECK
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, decode finished normally
- converged  out  1  parity satisfied at finish; valid from done, held until next accepted start
- iter_count  out  ITER_W  completed iterations; held after done
- cnu_en  out  1  CNU bank enable
- vnu_en  out  1  VNU bank enable
- ram_rd_en  out  1  intrinsic RAM read strobe (1-cycle read latency)
- ram_addr  out  ADDR_W  intrinsic RAM read address
- hd_wr_en  out  1  hard-decision buffer write strobe
- hd_addr  out  ADDR_W  hard-decision buffer write address

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous, active-low: rst_n=0 at a posedge forces state IDLE, phase counter 0, iter_count 0, and every output 0. Reset wins over all other inputs, including mid-phase.
- All outputs are registered or decoded from state and counter. No combinational path from inputs to outputs.
- Phase counter c resets to 0 on every state entry.
- IDLE:
  - start=1 and abort=0: latch max_iter (0 becomes 1), clear iter_count and converged, go to CNU.
  - start together with abort: ignored, stay IDLE.
- CNU (N_COLS+CNU_LAT cycles):
  - cnu_en=1 for c<N_COLS.
  - At c=N_COLS+CNU_LAT-1, go to VNU.
- VNU (N_COLS+VNU_LAT+1 cycles):
  - ram_rd_en=1 and ram_addr=c for c<N_COLS.
  - vnu_en=1 for 1<=c<=N_COLS+VNU_LAT, covering RAM latency plus pipeline flush.
  - hd_wr_en=1 for VNU_LAT+1<=c<=N_COLS+VNU_LAT, with hd_addr=c-VNU_LAT-1.
  - At c=N_COLS+VNU_LAT, go to CHECK.
- CHECK (1 cycle): iter_count <= iter_count+1, then:
  - parity_ok=1: converged<=1, go to DONE.
  - else if iter_count+1 == latched max_iter: converged<=0, go to DONE.
  - else go to CNU.
- DONE (1 cycle): done=1, go to IDLE. A start in DONE is ignored.
- start while busy: ignored, no effect.
- abort=1 in CNU, VNU, CHECK or DONE: IDLE next cycle with all strobes 0. No done pulse, converged=0, iter_count holds its last value.
- Outside the windows listed above, ram_addr and hd_addr are 0 and all strobes are 0.
- Iteration length is 2*N_COLS+CNU_LAT+VNU_LAT+2 cycles (14 at defaults).
- iter_count saturates naturally: at most max_iter ≤ 2^ITER_W-1.

Test Plan (defaults N_COLS=4, CNU_LAT=2, VNU_LAT=2):
- Reset: hold rst_n=0 with start=1 for 3 cycles → busy=0, all strobes 0, iter_count=0; release → stays IDLE until start.
- Single-iteration convergence: start at cycle 0, max_iter=5, parity_ok=1 → cnu_en high cycles 1-4; ram_rd_en high cycles 7-10 with ram_addr 0,1,2,3; vnu_en high cycles 8-13; hd_wr_en high cycles 10-13 with hd_addr 0-3; done at cycle 15 with converged=1 and iter_count=1.
- Limit reached: max_iter=3, parity_ok=0 → three CNU/VNU rounds, done at cycle 43 with converged=0 and iter_count=3.
- max_iter=0 → behaves as 1: done at cycle 15, iter_count=1.
- Abort at cycle 9 (mid-VNU) → cycle 10: busy=0, all strobes 0, no done pulse ever, converged=0; a new start then decodes normally.
- start pulsed during busy and in DONE → ignored; exactly one done pulse; a start one cycle after DONE (state IDLE) is accepted.

Source files
------------

// File: rtl/ldpc_iter_ctrl.sv
// LDPC decoder iteration scheduler: sequences CNU and VNU phases per iteration,
// drives intrinsic-RAM reads and hard-decision writes, and terminates on parity/limit/abort.
//
// state | meaning
// IDLE  | waiting for start; all strobes low
// CNU   | check-node issue (N_COLS cycles) then pipeline drain (CNU_LAT)
// VNU   | RAM read issue, VNU sum/output pipeline, hard-decision writes
// CHECK | count the iteration, decide converge / limit / next iteration
// DONE  | one-cycle done pulse back to the host
module ldpc_iter_ctrl #(
  parameter int N_COLS  = 4,
  parameter int ADDR_W  = 2,
  parameter int CNU_LAT = 2,
  parameter int VNU_LAT = 2,
  parameter int ITER_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              parity_ok,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
  output logic              cnu_en,
  output logic              vnu_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              hd_wr_en,
  output logic [ADDR_W-1:0] hd_addr
);

  localparam int CNU_LEN = N_COLS + CNU_LAT;
  localparam int VNU_LEN = N_COLS + VNU_LAT + 1;
  localparam int CNT_MAX = (CNU_LEN > VNU_LEN) ? CNU_LEN : VNU_LEN;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0] C_NCOLS   = CW'(N_COLS);
  localparam logic [CW-1:0] C_CNU_END = CW'(CNU_LEN - 1);
  localparam logic [CW-1:0] C_VNU_END = CW'(VNU_LEN - 1);
  localparam logic [CW-1:0] C_HD_OFF  = CW'(VNU_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNU   = 3'd1,
    S_VNU   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [ITER_W-1:0] iter_lim;
  logic [ITER_W-1:0] iter_inc;
  logic              accept;

  assign accept   = (state == S_IDLE) && start && !abort;
  assign iter_inc = iter_count + ITER_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      iter_count <= '0;
      iter_lim   <= '0;
      converged  <= 1'b0;
    end else begin
      state <= state_nxt;
      // every state change restarts the phase counter
      cnt   <= (state_nxt != state) ? '0 : cnt + CW'(1);
      if (accept) begin
        iter_lim   <= (max_iter == '0) ? ITER_W'(1) : max_iter;
        iter_count <= '0;
        converged  <= 1'b0;
      end else if (state != S_IDLE && abort) begin
        converged  <= 1'b0;
      end else if (state == S_CHECK) begin
        iter_count <= iter_inc;
        converged  <= parity_ok;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CNU;
      S_CNU:   if (cnt == C_CNU_END) state_nxt = S_VNU;
      S_VNU:   if (cnt == C_VNU_END) state_nxt = S_CHECK;
      S_CHECK: begin
        if (parity_ok || iter_inc == iter_lim) state_nxt = S_DONE;
        else                                   state_nxt = S_CNU;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && abort) state_nxt = S_IDLE;
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    cnu_en    = 1'b0;
    vnu_en    = 1'b0;
    ram_rd_en = 1'b0;
    ram_addr  = '0;
    hd_wr_en  = 1'b0;
    hd_addr   = '0;
    if (state == S_CNU) begin
      cnu_en = (cnt < C_NCOLS);
    end
    if (state == S_VNU) begin
      if (cnt < C_NCOLS) begin
        ram_rd_en = 1'b1;
        ram_addr  = ADDR_W'(cnt);
      end
      // vnu lags the read by one cycle for the RAM latency
      vnu_en = (cnt != '0);
      if (cnt >= C_HD_OFF) begin
        hd_wr_en = 1'b1;
        hd_addr  = ADDR_W'(cnt - C_HD_OFF);
      end
    end
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl at default parameters; expected strobe
// timing comes from the hand-derived cycle map of one 14-cycle iteration.
module tb_ldpc_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, parity_ok;
  logic [3:0] max_iter;
  logic       busy, done, converged, cnu_en, vnu_en, ram_rd_en, hd_wr_en;
  logic [3:0] iter_count;
  logic [1:0] ram_addr, hd_addr;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ldpc_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .max_iter(max_iter), .parity_ok(parity_ok),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
    .cnu_en(cnu_en), .vnu_en(vnu_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .hd_wr_en(hd_wr_en), .hd_addr(hd_addr)
  );

  // {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr}
  function automatic logic [9:0] exp_vec(int t, int n);
    int p, c;
    logic [9:0] v;
    v = '0;
    if (t >= 1 && t <= 14 * n) begin
      p = (t - 1) % 14;
      v[9] = 1'b1;
      if (p < 6) begin
        v[7] = (p < 4);
      end else if (p < 13) begin
        c = p - 6;
        v[6] = (c >= 1);
        if (c < 4) begin v[5] = 1'b1; v[4:3] = 2'(c); end
        if (c >= 3) begin v[2] = 1'b1; v[1:0] = 2'(c - 3); end
      end
    end else if (t == 14 * n + 1) begin
      v[9] = 1'b1;
      v[8] = 1'b1;
    end
    return v;
  endfunction

  function automatic int exp_iter(int t, int n);
    int k;
    k = (t >= 1) ? (t - 1) / 14 : 0;
    return (k > n) ? n : k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [3:0] mi);
    start = 1'b1;
    max_iter = mi;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; parity_ok = 1'b0; max_iter = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
      vectors++;
      if (got !== 10'd0 || iter_count !== 4'd0 || converged !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got vec=%b iter=%0d conv=%b, want vec=0 iter=0 conv=0",
                 i, got, iter_count, converged);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc%0d: got busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_converge();
    logic [9:0] got, want;
    parity_ok = 1'b1;
    issue_start(4'd5);
    for (int t = 1; t <= 17; t++) begin
      got  = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
      want = exp_vec(t, 1);
      vectors++;
      if (got !== want || iter_count !== 4'(exp_iter(t, 1))) begin
        errors++;
        $display("FAIL converge t=%0d: got vec=%b iter=%0d, want vec=%b iter=%0d",
                 t, got, iter_count, want, exp_iter(t, 1));
      end
      if (t >= 15) begin
        vectors++;
        if (converged !== 1'b1) begin
          errors++;
          $display("FAIL converge_flag t=%0d: got %b want 1", t, converged);
        end
      end
      tick();
    end
  endtask

  task automatic test_limit();
    logic [9:0] got, want;
    parity_ok = 1'b0;
    issue_start(4'd3);
    for (int t = 1; t <= 44; t++) begin
      got  = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
      want = exp_vec(t, 3);
      vectors++;
      if (got !== want || iter_count !== 4'(exp_iter(t, 3))) begin
        errors++;
        $display("FAIL limit t=%0d: got vec=%b iter=%0d, want vec=%b iter=%0d",
                 t, got, iter_count, want, exp_iter(t, 3));
      end
      tick();
    end
    vectors++;
    if (converged !== 1'b0 || iter_count !== 4'd3) begin
      errors++;
      $display("FAIL limit_final: got conv=%b iter=%0d, want conv=0 iter=3", converged, iter_count);
    end
  endtask

  task automatic test_zero_max();
    logic [9:0] got, want;
    parity_ok = 1'b0;
    issue_start(4'd0);
    for (int t = 1; t <= 16; t++) begin
      got  = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
      want = exp_vec(t, 1);
      vectors++;
      if (got !== want || iter_count !== 4'(exp_iter(t, 1))) begin
        errors++;
        $display("FAIL zero_max t=%0d: got vec=%b iter=%0d, want vec=%b iter=%0d",
                 t, got, iter_count, want, exp_iter(t, 1));
      end
      tick();
    end
    vectors++;
    if (converged !== 1'b0) begin
      errors++;
      $display("FAIL zero_max_conv: got %b want 0", converged);
    end
  endtask

  task automatic test_abort();
    logic [9:0] got, want;
    int dones;
    parity_ok = 1'b0;
    issue_start(4'd5);
    for (int t = 1; t <= 9; t++) begin
      got  = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
      want = exp_vec(t, 5);
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL abort_pre t=%0d: got vec=%b want vec=%b", t, got, want);
      end
      if (t < 9) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    got = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
    vectors++;
    if (got !== 10'd0 || converged !== 1'b0 || iter_count !== 4'd0) begin
      errors++;
      $display("FAIL abort_idle: got vec=%b conv=%b iter=%0d, want vec=0 conv=0 iter=0",
               got, converged, iter_count);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d busy/done cycles after abort, want 0", dones);
    end
    parity_ok = 1'b1;
    issue_start(4'd2);
    for (int t = 1; t <= 15; t++) begin
      got  = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
      want = exp_vec(t, 1);
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL abort_restart t=%0d: got vec=%b want vec=%b", t, got, want);
      end
      if (t < 15) tick();
    end
    vectors++;
    if (converged !== 1'b1 || iter_count !== 4'd1) begin
      errors++;
      $display("FAIL abort_restart_end: got conv=%b iter=%0d want conv=1 iter=1", converged, iter_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0] got, want;
    int dones;
    parity_ok = 1'b1;
    dones = 0;
    issue_start(4'd5);
    for (int t = 1; t <= 16; t++) begin
      got  = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
      want = exp_vec(t, 1);
      vectors++;
      if (got !== want || iter_count !== 4'(exp_iter(t, 1))) begin
        errors++;
        $display("FAIL b2b t=%0d: got vec=%b iter=%0d, want vec=%b iter=%0d",
                 t, got, iter_count, want, exp_iter(t, 1));
      end
      if (done === 1'b1) dones++;
      start = (t == 3 || t == 9 || t == 15 || t == 16);
      tick();
    end
    start = 1'b0;
    vectors++;
    if (dones != 1) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d pulses want 1", dones);
    end
    for (int t = 1; t <= 16; t++) begin
      got  = {busy, done, cnu_en, vnu_en, ram_rd_en, ram_addr, hd_wr_en, hd_addr};
      want = exp_vec(t, 1);
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_second t=%0d: got vec=%b want vec=%b", t, got, want);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_converge();
    test_limit();
    test_zero_max();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no summary by 200000, want finish");
    $fatal(1);
  end

endmodule
